// File: rtl/half_adder_pkg.sv
// Shared bit-level primitives for the half-adder slice.
package half_adder_pkg;

  function automatic logic ha_sum(input logic a, input logic b);
    return a ^ b;
  endfunction

  function automatic logic ha_carry(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = ha_sum(a_i, b_i);
  assign carry_o = ha_carry(a_i, b_i);

endmodule

// File: rtl/half_adder.sv
// Lane-parallel half adder with an optional output register stage and valid tracking.
module half_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             half_adder_in_valid,
  input  logic [WIDTH-1:0] half_adder_a,
  input  logic [WIDTH-1:0] half_adder_b,
  output logic             half_adder_out_valid,
  output logic [WIDTH-1:0] half_adder_sum,
  output logic [WIDTH-1:0] half_adder_carry
);

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] carry_comb;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a_i     (half_adder_a[i]),
      .b_i     (half_adder_b[i]),
      .sum_o   (sum_comb[i]),
      .carry_o (carry_comb[i])
    );
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_d, sum_q;
    logic [WIDTH-1:0] carry_d, carry_q;
    logic             out_valid_d, out_valid_q;

    // Data registers load every cycle; only the valid bit qualifies them.
    always_comb begin
      sum_d       = sum_comb;
      carry_d     = carry_comb;
      out_valid_d = half_adder_in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q       <= '0;
        carry_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        sum_q       <= sum_d;
        carry_q     <= carry_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign half_adder_sum       = sum_q;
    assign half_adder_carry     = carry_q;
    assign half_adder_out_valid = out_valid_q;
  end else begin : g_comb
    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign half_adder_sum       = sum_comb;
    assign half_adder_carry     = carry_comb;
    assign half_adder_out_valid = half_adder_in_valid;
  end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: four half_adder configurations against a lane-arithmetic model.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        a1, b1, v1, s1, c1, ov1;
  logic [7:0]  a8, b8, s8, c8;
  logic        v8, ov8;
  logic        a0, b0, v0, s0, c0, ov0;
  logic [15:0] a16, b16, s16, c16;
  logic        v16, ov16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .REGISTERED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .half_adder_in_valid(v1),
    .half_adder_a(a1), .half_adder_b(b1),
    .half_adder_out_valid(ov1), .half_adder_sum(s1), .half_adder_carry(c1));

  half_adder #(.WIDTH(8), .REGISTERED(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .half_adder_in_valid(v8),
    .half_adder_a(a8), .half_adder_b(b8),
    .half_adder_out_valid(ov8), .half_adder_sum(s8), .half_adder_carry(c8));

  half_adder #(.WIDTH(1), .REGISTERED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .half_adder_in_valid(v0),
    .half_adder_a(a0), .half_adder_b(b0),
    .half_adder_out_valid(ov0), .half_adder_sum(s0), .half_adder_carry(c0));

  half_adder #(.WIDTH(16), .REGISTERED(1'b1)) u16 (
    .clk(clk), .rst_n(rst_n), .half_adder_in_valid(v16),
    .half_adder_a(a16), .half_adder_b(b16),
    .half_adder_out_valid(ov16), .half_adder_sum(s16), .half_adder_carry(c16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per lane the two-bit arithmetic sum a+b gives {carry, sum}; result packed as {carry[15:0], sum[15:0]}.
  function automatic logic [31:0] ha_model(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    logic [1:0]  t;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      t = 2'(a[i]) + 2'(b[i]);
      r[i]      = t[0];
      r[16 + i] = t[1];
    end
    return r;
  endfunction

  logic [31:0] e1 = '0, e8 = '0, e16 = '0;
  logic        ev1 = 1'b0, ev8 = 1'b0, ev16 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1 <= '0; e8 <= '0; e16 <= '0;
      ev1 <= 1'b0; ev8 <= 1'b0; ev16 <= 1'b0;
    end else begin
      e1  <= ha_model(16'(a1), 16'(b1));
      e8  <= ha_model(16'(a8), 16'(b8));
      e16 <= ha_model(a16, b16);
      ev1 <= v1; ev8 <= v8; ev16 <= v16;
    end
  end

  logic [31:0] m0;
  always @(negedge clk) begin
    chk("u1_sum",    32'(s1),   32'(e1[0]));
    chk("u1_carry",  32'(c1),   32'(e1[16]));
    chk("u1_valid",  32'(ov1),  32'(ev1));
    chk("u8_sum",    32'(s8),   32'(e8[7:0]));
    chk("u8_carry",  32'(c8),   32'(e8[23:16]));
    chk("u8_valid",  32'(ov8),  32'(ev8));
    chk("u16_sum",   32'(s16),  32'(e16[15:0]));
    chk("u16_carry", 32'(c16),  32'(e16[31:16]));
    chk("u16_valid", 32'(ov16), 32'(ev16));
    chk("u16_excl",  32'(s16 & c16), 32'd0);
    m0 = ha_model(16'(a0), 16'(b0));
    chk("u0_sum",    32'(s0),   32'(m0[0]));
    chk("u0_carry",  32'(c0),   32'(m0[16]));
    chk("u0_valid",  32'(ov0),  32'(v0));
  end

  logic a_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic b_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic xs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic xc  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
    a0 = 1'b0; b0 = 1'b0; v0 = 1'b0;
    a16 = '0; b16 = '0; v16 = 1'b0;

    // Reset holds zeros across a clock edge even with live inputs.
    #12;
    chk("rst_u1_sum",   32'(s1),  32'd0);
    chk("rst_u1_carry", 32'(c1),  32'd0);
    chk("rst_u1_valid", 32'(ov1), 32'd0);
    chk("rst_u8_carry", 32'(c8),  32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      chk("dir_sum",   32'(s1),  32'(xs[k]));
      chk("dir_carry", 32'(c1),  32'(xc[k]));
      chk("dir_valid", 32'(ov1), 32'd1);
      if (k == 0) begin
        chk("w8_sum_f0cc",   32'(s8), 32'h3C);
        chk("w8_carry_f0cc", 32'(c8), 32'hC0);
        a8 = 8'hFF; b8 = 8'hFF;
      end
      if (k == 1) begin
        chk("w8_sum_ffff",   32'(s8), 32'h00);
        chk("w8_carry_ffff", 32'(c8), 32'hFF);
      end
      if (k < 3) begin
        a1 = a_v[k+1]; b1 = b_v[k+1];
      end
      a0 = a_v[k]; b0 = b_v[k]; v0 = (k % 2 == 0);
      #1;
      chk("comb_sum",   32'(s0),  32'(xs[k]));
      chk("comb_carry", 32'(c0),  32'(xc[k]));
      chk("comb_valid", 32'(ov0), 32'((k % 2) == 0));
    end

    // Mid-stream reset discards the in-flight result without a clock.
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #2;
    chk("mid_pre_carry", 32'(c1),  32'd1);
    chk("mid_pre_valid", 32'(ov1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum",   32'(s1),  32'd0);
    chk("mid_rst_carry", 32'(c1),  32'd0);
    chk("mid_rst_valid", 32'(ov1), 32'd0);
    @(posedge clk); #2;
    chk("mid_hold_carry", 32'(c1),  32'd0);
    chk("mid_hold_valid", 32'(ov1), 32'd0);
    a1 = 1'b1; b1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("mid_post_sum",   32'(s1),  32'd1);
    chk("mid_post_carry", 32'(c1),  32'd0);
    chk("mid_post_valid", 32'(ov1), 32'd1);

    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #2;
      a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'($urandom_range(0, 1));
      a1  = 1'($urandom);  b1  = 1'($urandom);  v1  = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);  b8  = 8'($urandom);  v8  = 1'($urandom_range(0, 1));
      a0  = 1'($urandom);  b0  = 1'($urandom);  v0  = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
